// File: rtl/alu_lockstep_pkg.sv
// Shared types for the lockstep ALU checker: lane opcodes and pipeline mode encodings.
package alu_lockstep_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_e;

  localparam logic MODE_LOCKSTEP = 1'b0;
  localparam logic MODE_DUAL     = 1'b1;

endpackage

// File: rtl/alu_lane.sv
// Combinational ALU lane returning {carry, result}; carry is the borrow for SUB.
module alu_lane
  import alu_lockstep_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH:0]   res
);

  always_comb begin
    res = '0;
    case (op)
      // Zero-extended subtraction leaves bit WIDTH set exactly when a < b.
      ALU_ADD: res = {1'b0, a} + {1'b0, b};
      ALU_SUB: res = {1'b0, a} - {1'b0, b};
      ALU_AND: res = {1'b0, a & b};
      ALU_XOR: res = {1'b0, a ^ b};
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_lockstep_checker.sv
// Two ALU lanes in a two-stage pipeline; in lockstep mode the lanes are compared and
// mismatches drive a saturating counter, sticky flag, first-error capture and IRQ.
module alu_lockstep_checker
  import alu_lockstep_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             mode_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] a0_i,
  input  logic [WIDTH-1:0] b0_i,
  input  logic [WIDTH-1:0] a1_i,
  input  logic [WIDTH-1:0] b1_i,
  input  logic [1:0]       sel0_i,
  input  logic [1:0]       sel1_i,
  input  logic             inj_i,
  input  logic             clr_i,
  input  logic             irq_en_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out0_o,
  output logic [WIDTH-1:0] out1_o,
  output logic             cy0_o,
  output logic             cy1_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             mismatch_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             err_sticky_o,
  output logic [WIDTH:0]   cap0_o,
  output logic [WIDTH:0]   cap1_o,
  output logic             irq_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   INJ_BIT = {{WIDTH{1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic             vld_p1, mode_p1;
  logic [WIDTH-1:0] a0_p1, b0_p1, a1_p1, b1_p1;
  alu_op_e          sel0_p1, sel1_p1;

  logic [WIDTH:0]   res0, res1_raw, res1;
  logic [WIDTH-1:0] diff;
  logic             miss;

  logic             vld_p2, mismatch_p2;
  logic [WIDTH:0]   res0_p2, res1_p2;
  logic [WIDTH-1:0] diff_p2;

  logic [CNT_W-1:0] err_cnt, err_cnt_nxt;
  logic             sticky, sticky_nxt;
  logic [WIDTH:0]   cap0, cap1, cap0_nxt, cap1_nxt;

  // ---- Stage 1: operand capture; lockstep mirrors lane 0 into lane 1 ----
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      vld_p1  <= 1'b0;
      mode_p1 <= MODE_LOCKSTEP;
      a0_p1   <= '0;
      b0_p1   <= '0;
      a1_p1   <= '0;
      b1_p1   <= '0;
      sel0_p1 <= ALU_ADD;
      sel1_p1 <= ALU_ADD;
    end else begin
      vld_p1 <= in_valid_i;
      if (in_valid_i) begin
        mode_p1 <= mode_i;
        a0_p1   <= a0_i;
        b0_p1   <= b0_i;
        sel0_p1 <= alu_op_e'(sel0_i);
        if (mode_i == MODE_LOCKSTEP) begin
          a1_p1   <= a0_i;
          b1_p1   <= b0_i;
          sel1_p1 <= alu_op_e'(sel0_i);
        end else begin
          a1_p1   <= a1_i;
          b1_p1   <= b1_i;
          sel1_p1 <= alu_op_e'(sel1_i);
        end
      end
    end
  end

  alu_lane #(.WIDTH(WIDTH)) u_lane0 (.a(a0_p1), .b(b0_p1), .op(sel0_p1), .res(res0));
  alu_lane #(.WIDTH(WIDTH)) u_lane1 (.a(a1_p1), .b(b1_p1), .op(sel1_p1), .res(res1_raw));

  always_comb begin
    res1 = inj_i ? (res1_raw ^ INJ_BIT) : res1_raw;
    diff = res0[WIDTH-1:0] ^ res1[WIDTH-1:0];
    miss = vld_p1 && (mode_p1 == MODE_LOCKSTEP) && ((|diff) || (res0[WIDTH] ^ res1[WIDTH]));
  end

  // ---- Stage 2: results and compare outcome ----
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      vld_p2      <= 1'b0;
      mismatch_p2 <= 1'b0;
      res0_p2     <= '0;
      res1_p2     <= '0;
      diff_p2     <= '0;
    end else begin
      vld_p2      <= vld_p1;
      mismatch_p2 <= miss;
      if (vld_p1) begin
        res0_p2 <= res0;
        res1_p2 <= res1;
        diff_p2 <= diff;
      end
    end
  end

  // Clear is folded in before the mismatch so a same-cycle mismatch is still recorded.
  always_comb begin
    err_cnt_nxt = clr_i ? '0 : err_cnt;
    sticky_nxt  = clr_i ? 1'b0 : sticky;
    cap0_nxt    = clr_i ? '0 : cap0;
    cap1_nxt    = clr_i ? '0 : cap1;
    if (mismatch_p2) begin
      err_cnt_nxt = sat_inc(err_cnt_nxt);
      if (!sticky_nxt) begin
        sticky_nxt = 1'b1;
        cap0_nxt   = res0_p2;
        cap1_nxt   = res1_p2;
      end
    end
  end

  // ---- Stage 3: error bookkeeping ----
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      err_cnt <= '0;
      sticky  <= 1'b0;
      cap0    <= '0;
      cap1    <= '0;
    end else begin
      err_cnt <= err_cnt_nxt;
      sticky  <= sticky_nxt;
      cap0    <= cap0_nxt;
      cap1    <= cap1_nxt;
    end
  end

  assign out_valid_o  = vld_p2;
  assign out0_o       = res0_p2[WIDTH-1:0];
  assign out1_o       = res1_p2[WIDTH-1:0];
  assign cy0_o        = res0_p2[WIDTH];
  assign cy1_o        = res1_p2[WIDTH];
  assign diff_o       = diff_p2;
  assign mismatch_o   = mismatch_p2;
  assign err_cnt_o    = err_cnt;
  assign err_sticky_o = sticky;
  assign cap0_o       = cap0;
  assign cap1_o       = cap1;
  assign irq_o        = sticky & irq_en_i;

endmodule

// File: tb/tb_alu_lockstep_checker.sv
// Directed bench for alu_lockstep_checker (WIDTH=4, CNT_W=8) with hand-computed expectations.
module tb_alu_lockstep_checker;

  localparam logic       LOCK = 1'b0;
  localparam logic       DUAL = 1'b1;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;

  logic       clk, rst_n, mode, in_valid, inj, clr, irq_en;
  logic [3:0] a0, b0, a1, b1;
  logic [1:0] sel0, sel1;
  logic       out_valid, cy0, cy1, mismatch, sticky, irq;
  logic [3:0] out0, out1, diff;
  logic [7:0] err_cnt;
  logic [4:0] cap0, cap1;

  int n_checks = 0;
  int n_fail   = 0;

  alu_lockstep_checker #(.WIDTH(4), .CNT_W(8)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .mode_i(mode), .in_valid_i(in_valid),
    .a0_i(a0), .b0_i(b0), .a1_i(a1), .b1_i(b1), .sel0_i(sel0), .sel1_i(sel1),
    .inj_i(inj), .clr_i(clr), .irq_en_i(irq_en),
    .out_valid_o(out_valid), .out0_o(out0), .out1_o(out1), .cy0_o(cy0), .cy1_o(cy1),
    .diff_o(diff), .mismatch_o(mismatch), .err_cnt_o(err_cnt), .err_sticky_o(sticky),
    .cap0_o(cap0), .cap1_o(cap1), .irq_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m, input logic [3:0] xa0, input logic [3:0] xb0,
                       input logic [1:0] xs0, input logic [3:0] xa1,
                       input logic [3:0] xb1, input logic [1:0] xs1);
    mode = m; in_valid = 1'b1;
    a0 = xa0; b0 = xb0; sel0 = xs0;
    a1 = xa1; b1 = xb1; sel1 = xs1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = LOCK; in_valid = 1'b1; inj = 1'b0; clr = 1'b0; irq_en = 1'b1;
    a0 = 4'd5; b0 = 4'd6; a1 = 4'd0; b1 = 4'd0; sel0 = OP_ADD; sel1 = OP_ADD;
    step(); step(); step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0d expected 0", out_valid); end
    n_checks++; if (out0 !== 4'd0) begin n_fail++; $display("FAIL reset_out0 got %0d expected 0", out0); end
    n_checks++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL reset_mismatch got %0d expected 0", mismatch); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got %0d expected 0", err_cnt); end
    n_checks++; if (sticky !== 1'b0 || irq !== 1'b0) begin n_fail++; $display("FAIL reset_sticky_irq got %0d/%0d expected 0/0", sticky, irq); end
    n_checks++; if (cap0 !== 5'd0 || cap1 !== 5'd0) begin n_fail++; $display("FAIL reset_cap got %0d/%0d expected 0/0", cap0, cap1); end
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_lockstep_add();
    drive(LOCK, 4'd9, 4'd8, OP_ADD, 4'd2, 4'd3, OP_XOR);
    step(); idle(); step();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got %0d expected 1", out_valid); end
    n_checks++; if (out0 !== 4'd1 || out1 !== 4'd1) begin n_fail++; $display("FAIL add_out got %0d/%0d expected 1/1", out0, out1); end
    n_checks++; if (cy0 !== 1'b1 || cy1 !== 1'b1) begin n_fail++; $display("FAIL add_cy got %0d/%0d expected 1/1", cy0, cy1); end
    n_checks++; if (diff !== 4'd0 || mismatch !== 1'b0) begin n_fail++; $display("FAIL add_cmp got diff %0d mis %0d expected 0/0", diff, mismatch); end
    step();
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL add_cnt got %0d expected 0", err_cnt); end
  endtask

  task automatic test_lockstep_sub_inj();
    drive(LOCK, 4'd3, 4'd5, OP_SUB, 4'd0, 4'd0, OP_ADD);
    step(); idle(); inj = 1'b1; step(); inj = 1'b0;
    n_checks++; if (out0 !== 4'd14 || out1 !== 4'd15) begin n_fail++; $display("FAIL sub_out got %0d/%0d expected 14/15", out0, out1); end
    n_checks++; if (cy0 !== 1'b1 || cy1 !== 1'b1) begin n_fail++; $display("FAIL sub_cy got %0d/%0d expected 1/1", cy0, cy1); end
    n_checks++; if (diff !== 4'd1 || mismatch !== 1'b1) begin n_fail++; $display("FAIL sub_cmp got diff %0d mis %0d expected 1/1", diff, mismatch); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL sub_cnt_early got %0d expected 0", err_cnt); end
    step();
    n_checks++; if (err_cnt !== 8'd1 || sticky !== 1'b1) begin n_fail++; $display("FAIL sub_err got cnt %0d sticky %0d expected 1/1", err_cnt, sticky); end
    n_checks++; if (cap0 !== 5'b11110 || cap1 !== 5'b11111) begin n_fail++; $display("FAIL sub_cap got %b/%b expected 11110/11111", cap0, cap1); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL sub_irq got %0d expected 1", irq); end
    n_checks++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL sub_mis_drop got %0d expected 0", mismatch); end
    irq_en = 1'b0; #1;
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_mask got %0d expected 0", irq); end
    irq_en = 1'b1; #1;
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_unmask got %0d expected 1", irq); end
  endtask

  task automatic test_dual();
    drive(DUAL, 4'd12, 4'd10, OP_AND, 4'd12, 4'd10, OP_XOR);
    step(); idle(); inj = 1'b1; step(); inj = 1'b0;
    n_checks++; if (out0 !== 4'd8 || out1 !== 4'd7) begin n_fail++; $display("FAIL dual_out got %0d/%0d expected 8/7", out0, out1); end
    n_checks++; if (cy0 !== 1'b0 || cy1 !== 1'b0) begin n_fail++; $display("FAIL dual_cy got %0d/%0d expected 0/0", cy0, cy1); end
    n_checks++; if (mismatch !== 1'b0 || diff !== 4'd15) begin n_fail++; $display("FAIL dual_cmp got mis %0d diff %0d expected 0/15", mismatch, diff); end
    step();
    n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL dual_cnt got %0d expected 1", err_cnt); end
  endtask

  task automatic test_back_to_back();
    drive(DUAL, 4'd1, 4'd1, OP_ADD, 4'd2, 4'd2, OP_ADD);
    step();
    drive(LOCK, 4'd5, 4'd6, OP_ADD, 4'd9, 4'd9, OP_SUB);
    step(); idle();
    n_checks++; if (out0 !== 4'd2 || out1 !== 4'd4 || mismatch !== 1'b0) begin n_fail++; $display("FAIL b2b_dual got %0d/%0d mis %0d expected 2/4/0", out0, out1, mismatch); end
    step();
    n_checks++; if (out0 !== 4'd11 || out1 !== 4'd11 || mismatch !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_lock got %0d/%0d mis %0d vld %0d expected 11/11/0/1", out0, out1, mismatch, out_valid); end
    step();
    n_checks++; if (out_valid !== 1'b0 || mismatch !== 1'b0) begin n_fail++; $display("FAIL bubble_ctrl got vld %0d mis %0d expected 0/0", out_valid, mismatch); end
    n_checks++; if (out0 !== 4'd11 || out1 !== 4'd11) begin n_fail++; $display("FAIL bubble_hold got %0d/%0d expected 11/11", out0, out1); end
    n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL b2b_cnt got %0d expected 1", err_cnt); end
  endtask

  task automatic test_saturation();
    clr = 1'b1; step(); clr = 1'b0;
    n_checks++; if (err_cnt !== 8'd0 || sticky !== 1'b0 || cap0 !== 5'd0) begin n_fail++; $display("FAIL clr got cnt %0d sticky %0d cap0 %0d expected 0/0/0", err_cnt, sticky, cap0); end
    inj = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (i == 0) drive(LOCK, 4'd3, 4'd5, OP_SUB, 4'd0, 4'd0, OP_ADD);
      else        drive(LOCK, 4'd1, 4'd1, OP_ADD, 4'd0, 4'd0, OP_ADD);
      step();
    end
    idle(); step(); step();
    inj = 1'b0;
    n_checks++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_cnt got %0d expected 255", err_cnt); end
    n_checks++; if (cap0 !== 5'b11110 || cap1 !== 5'b11111) begin n_fail++; $display("FAIL sat_cap got %b/%b expected 11110/11111", cap0, cap1); end
  endtask

  task automatic test_clear_collision();
    clr = 1'b1; step(); clr = 1'b0;
    inj = 1'b1;
    for (int i = 0; i < 37; i++) begin
      drive(LOCK, 4'd3, 4'd5, OP_SUB, 4'd0, 4'd0, OP_ADD);
      step();
    end
    idle(); step(); step();
    n_checks++; if (err_cnt !== 8'd37 || cap0 !== 5'b11110) begin n_fail++; $display("FAIL pre_clr got cnt %0d cap0 %b expected 37/11110", err_cnt, cap0); end
    drive(LOCK, 4'd7, 4'd2, OP_ADD, 4'd0, 4'd0, OP_ADD);
    step(); idle(); step();
    n_checks++; if (mismatch !== 1'b1 || out0 !== 4'd9 || out1 !== 4'd8) begin n_fail++; $display("FAIL coll_out got mis %0d %0d/%0d expected 1 9/8", mismatch, out0, out1); end
    clr = 1'b1; step(); clr = 1'b0; inj = 1'b0;
    n_checks++; if (err_cnt !== 8'd1 || sticky !== 1'b1) begin n_fail++; $display("FAIL coll_err got cnt %0d sticky %0d expected 1/1", err_cnt, sticky); end
    n_checks++; if (cap0 !== 5'b01001 || cap1 !== 5'b01000) begin n_fail++; $display("FAIL coll_cap got %b/%b expected 01001/01000", cap0, cap1); end
  endtask

  task automatic test_async_reset();
    drive(LOCK, 4'd9, 4'd8, OP_ADD, 4'd0, 4'd0, OP_ADD);
    step();
    drive(DUAL, 4'd12, 4'd10, OP_AND, 4'd12, 4'd10, OP_XOR);
    step(); idle();
    n_checks++; if (out_valid !== 1'b1 || irq !== 1'b1) begin n_fail++; $display("FAIL pre_rst got vld %0d irq %0d expected 1/1", out_valid, irq); end
    #2 rst_n = 1'b0; #1;
    n_checks++; if (out_valid !== 1'b0 || out0 !== 4'd0 || out1 !== 4'd0 || cy0 !== 1'b0) begin n_fail++; $display("FAIL rst_data got vld %0d %0d/%0d cy %0d expected 0", out_valid, out0, out1, cy0); end
    n_checks++; if (err_cnt !== 8'd0 || sticky !== 1'b0 || irq !== 1'b0) begin n_fail++; $display("FAIL rst_err got cnt %0d sticky %0d irq %0d expected 0", err_cnt, sticky, irq); end
    n_checks++; if (cap0 !== 5'd0 || cap1 !== 5'd0) begin n_fail++; $display("FAIL rst_cap got %0d/%0d expected 0/0", cap0, cap1); end
    #1 rst_n = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rel_drop1 got %0d expected 0", out_valid); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rel_drop2 got %0d expected 0", out_valid); end
    drive(LOCK, 4'd3, 4'd5, OP_SUB, 4'd0, 4'd0, OP_ADD);
    step(); idle();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rel_n1 got %0d expected 0", out_valid); end
    step();
    n_checks++; if (out_valid !== 1'b1 || out0 !== 4'd14 || mismatch !== 1'b0) begin n_fail++; $display("FAIL rel_n2 got vld %0d out0 %0d mis %0d expected 1/14/0", out_valid, out0, mismatch); end
  endtask

  initial begin
    test_reset();
    test_lockstep_add();
    test_lockstep_sub_inj();
    test_dual();
    test_back_to_back();
    test_saturation();
    test_clear_collision();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_lockstep_checker.md
# alu_lockstep_checker

Parametrised successor to the dual 4-bit ALU/XOR comparator in the user project area. Two identical ALU lanes run in a registered two-stage pipeline. In LOCKSTEP mode both lanes see the same operands and every result is compared. In DUAL mode the lanes are independent and comparison is off. Mismatches feed a saturating error counter, a sticky flag with first-error capture, and an IRQ. The block sits behind the wrapper's io/LA pins.

## Interface
- `WIDTH`, 4: operand and result width per lane, ≥2.
- `CNT_W`, 8: mismatch counter width.
- `wb_clk_i`  in  1  block clock.
- `wb_rst_ni`  in  1  asynchronous active-low reset.
- `mode_i`  in  1  0 = LOCKSTEP (lane 1 uses lane 0 operands/op; compare on), 1 = DUAL (independent; compare off).
- `in_valid_i`  in  1  operand qualifier.
- `a0_i`, `b0_i`, `a1_i`, `b1_i`  in  WIDTH each  lane operands.
- `sel0_i`, `sel1_i`  in  2 each  op select: 0 ADD, 1 SUB, 2 AND, 3 XOR.
- `inj_i`  in  1  fault injection; flips result bit 0 of lane 1 in stage 2.
- `clr_i`  in  1  sync clear of the counter, sticky flag and capture.
- `irq_en_i`  in  1  IRQ enable.
- `out_valid_o`  out  1  results valid.
- `out0_o`, `out1_o`  out  WIDTH  lane results.
- `cy0_o`, `cy1_o`  out  1  lane carry/borrow.
- `diff_o`  out  WIDTH  `out0_o ^ out1_o`.
- `mismatch_o`  out  1  compare failure for the current output.
- `err_cnt_o`  out  CNT_W  saturating mismatch count.
- `err_sticky_o`  out  1  set on first mismatch.
- `cap0_o`, `cap1_o`  out  WIDTH+1  `{carry, result}` of both lanes at the first mismatch.
- `irq_o`  out  1  `err_sticky_o & irq_en_i`.

## Operation
- **ALU arithmetic**, all modulo 2^WIDTH:
  - ADD: carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB: A−B; carry = borrow, i.e. 1 iff A<B.
  - AND and XOR: carry = 0.
- **Stage 1** registers mode, operands, selects and valid. In LOCKSTEP, the lane 1 register loads lane 0 operands and select.
- **Stage 2** computes both lanes, applies `inj_i` sampled in that cycle, and registers the results, `diff_o` and `mismatch_o`.
- **Mismatch rule:** `mismatch_o` = stage-2 valid & stage-2 mode==LOCKSTEP & (|diff | cy0^cy1). It is 0 whenever `out_valid_o`=0.
- **Error counter:** increments on each cycle with `mismatch_o`=1 and holds at 2^CNT_W−1.
- **Sticky and capture:** on a mismatch while `err_sticky_o`=0, sticky is set and `cap0_o`/`cap1_o` load. Later mismatches do not overwrite the capture.
- **Clear:** `clr_i` zeroes the counter, sticky flag and capture.
  - If `clr_i` and `mismatch_o` are both 1 in the same cycle, clear applies first and the mismatch is then recorded: counter=1, sticky=1, capture loaded.
- **Mode changes** take effect per transaction, because mode travels down the pipeline with its data. A mode switch never corrupts an in-flight compare.
- **Bubbles:** data registers hold when `in_valid_i`=0; only valid propagates.

## Timing
- **Latency:** operands presented with `in_valid_i` in cycle N appear on `out_valid_o`/results/`mismatch_o` in cycle N+2.
- **Error state:** `err_cnt_o`, `err_sticky_o`, capture and `irq_o` reflect a mismatch in cycle N+3.
- **Throughput:** one transaction per cycle, no backpressure.
- **Reset:** all outputs and pipeline state are 0, including valid, results, counter, sticky, capture and irq.
- **Reset mid-operation:** in-flight transactions are dropped.
- **Release:** the first valid output comes 2 cycles after the first post-reset `in_valid_i`.
- `irq_o` is a registered-flag combinational AND: it changes in the cycle `irq_en_i` changes.

## Structure
- Package `alu_lockstep_pkg`:
  - op enum: `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_XOR`.
  - mode constants: `MODE_LOCKSTEP`, `MODE_DUAL`.
- Sub-module `alu_lane #(WIDTH)`: combinational ALU returning `{carry, result}`, instantiated twice.
- The top level holds the pipeline registers, compare, counter and capture logic.

## Test plan
All scenarios use WIDTH=4 and CNT_W=8.
- **LOCKSTEP clean ADD:** a0=9, b0=8, sel0=ADD, inj=0 → cycle N+2: out0=out1=1, cy0=cy1=1, diff=0, mismatch=0; counter stays 0.
- **LOCKSTEP SUB with injection:** a0=3, b0=5, SUB, inj=1 at stage 2 → out0=14, out1=15, cy=1/1, diff=1, mismatch=1. At N+3: count=1, sticky=1, cap0=5'b11110, cap1=5'b11111, irq=1 with irq_en=1.
- **DUAL independent lanes:** lane0 AND 12&10, lane1 XOR 12^10, inj=1 → out0=8, out1=7 (6 flipped to 7), mismatch=0, count unchanged.
- **Saturation:** 300 back-to-back injected mismatches → counter reaches 255 and holds; capture equals the first failure only.
- **Clear collision:** `clr_i` in the same cycle as a mismatch with count=37 → next cycle count=1, sticky=1, new capture loaded.
- **Async reset mid-stream:** assert `wb_rst_ni` low with transactions in stages 1 and 2 → all outputs 0 immediately; after release, no `out_valid_o` until 2 cycles after a new `in_valid_i`.
